wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage plus general-purpose register file for the five-stage openMIPS core. Receives the execute result triple (write-enable, destination address, result word) through a pipelined MEM/WB latch, commits it to a 32 x 32-bit register array one cycle later, and serves the two decode-stage read ports that feed the ALU operand inputs. Supports stall/flush, hardwired-zero r0, and optional write-to-read forwarding.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers
- DATA_W, 32, register width in bits

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_  in  1  reset; one clock, synchronous, active-low
- wb_i_wreg  in  1  result write-enable from MEM stage
- wb_i_waddr  in  5  destination register
- wb_i_wdata  in  32  result word
- wb_i_stall  in  1  hold the MEM/WB latch
- wb_i_flush  in  1  invalidate the incoming result
- rd0_en / rd1_en  in  1  read-port enables
- rd0_addr / rd1_addr  in  5  read addresses
- rd0_data / rd1_data  out  32  read data (combinational)
- wb_o_wreg  out  1  latched write-enable (committing this cycle)
- wb_o_waddr  out  5  latched destination
- wb_o_wdata  out  32  latched result

## Operation
- Stage 1, MEM/WB latch, each edge with rst_ high:
  - flush=1: wb_o_wreg <= 0; waddr/wdata <= 0 (flush beats stall)
  - else stall=1: hold all three
  - else: capture wb_i_wreg/waddr/wdata
- Stage 2, commit: each edge with rst_ high, if wb_o_wreg=1 and wb_o_waddr!=0, array[wb_o_waddr] <= wb_o_wdata. Commit proceeds during stall; the repeated identical write is idempotent.
- Read port n:
  - rst_ low -> 0
  - rdn_en=0 -> 0
  - rdn_addr=0 -> 0, always, including during bypass
  - bypass hit (macro on, wb_o_wreg=1, wb_o_waddr==rdn_addr) -> wb_o_wdata
  - otherwise array[rdn_addr]
- Writes to r0 are discarded; r0 reads always return 0.
- Both ports may address the same register; each returns identical data.

## Timing
- Reset, sampled at edge with rst_=0: wb_o_wreg=0, wb_o_waddr=0, wb_o_wdata=0, all array entries 0. A write pending in the latch at that edge is dropped, not committed.
- Result presented at edge N is latched at N, appears on wb_o_* after N, and is in the array after edge N+1.
- Read data is combinational from addr/en; no read latency.
- With bypass: a read in cycle N+1 (between edges N and N+1) sees the new value.
- Without bypass: the first read returning the new value is in cycle N+2.

## Configuration
- REGFILE_BYPASS_EN defined: read ports forward wb_o_wdata on address match with wb_o_wreg=1, except for r0.
- Undefined: no forwarding. Reads return array contents only, and decode must interlock for one extra cycle after a dependent write.

## Structure
- Shared defines header holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_NUM=32
  - ZERO_WORD=32'h0, NOP_REG_ADDR=5'b0
  - WRITE_ENABLE / WRITE_DISABLE constants used by ex and id
- One sub-module, regfile_ram: the array with one synchronous write port, two asynchronous read ports, and synchronous clear.
- The latch, r0 masking and bypass mux stay in wb_regfile.

## Test plan
- Reset then read: hold rst_=0 for 2 cycles and read r5/r31 -> rd0_data=rd1_data=0, wb_o_wreg=0.
- Basic write: present wreg=1, waddr=3, wdata=32'hDEADBEEF -> wb_o_* match after the next edge; rd0_addr=3 returns DEADBEEF from the following cycle, with bypass on (cycle N+1) and with bypass off (cycle N+2).
- r0: write 32'hFFFFFFFF to addr 0, then read addr 0 on both ports -> 0 in every cycle.
- Stall/flush: assert stall while a new write of 32'h1 to r7 is presented -> latch holds previous value and r7 stays unchanged. Assert flush and stall together -> wb_o_wreg=0 next cycle and no commit.
- Reset mid-operation: latch a write of 32'hA5A5A5A5 to r9, assert rst_=0 at the next edge -> r9 reads 0 after reset releases.
- Dual read: both ports read r12 holding 32'h12345678 while the same register is being rewritten with 32'h0BADF00D -> both ports return the same value (new with bypass, old without).

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared register-file constants for the openMIPS pipeline.
// Holds the architectural sizing, the zero word, the NOP destination and the
// write-enable encodings that the execute and decode stages also use.
package wb_regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 32;

    localparam logic [REG_DATA_W-1:0] ZERO_WORD    = 32'h0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'b0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Number of decode-stage read ports on the register file.
    localparam int RD_PORTS = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/wb_regfile_regfile_ram.sv
// regfile_ram: REG_NUM x DATA_W register array.
// One synchronous write port, NRD asynchronous read ports, synchronous clear.
// Ports:
//   clk, rst_    clock, synchronous active-low clear of every entry
//   we/waddr/wdata  write port (no r0 filtering here; caller gates we)
//   raddr[NRD]   read addresses
//   rdata[NRD]   raw array contents, combinational
module regfile_ram #(
    parameter  int REG_NUM = 32,
    parameter  int DATA_W  = 32,
    parameter  int NRD     = 2,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [NRD-1:0][AW-1:0]    raddr,
    output logic [NRD-1:0][DATA_W-1:0] rdata
);

    logic [REG_NUM-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        assign rdata[p] = mem[raddr[p]];
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and general-purpose register file.
// The MEM/WB latch captures the result triple; the latched result commits to
// the array on the following edge. Two combinational read ports feed decode.
// Build option: define REGFILE_BYPASS_EN to forward the latched result to the
// read ports on an address match, so a dependent read sees the value one
// cycle earlier than the array does.
// Ports:
//   clk, rst_                      clock, synchronous active-low reset
//   wb_i_wreg/waddr/wdata          result from MEM stage
//   wb_i_stall, wb_i_flush         hold / invalidate the latch (flush wins)
//   rd0_en/addr/data, rd1_*        read ports (data combinational)
//   wb_o_wreg/waddr/wdata          latched result, committing this cycle
module wb_regfile #(
    parameter  int REG_NUM = wb_regfile_pkg::REG_NUM,
    parameter  int DATA_W  = wb_regfile_pkg::REG_DATA_W,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              wb_i_wreg,
    input  logic [AW-1:0]     wb_i_waddr,
    input  logic [DATA_W-1:0] wb_i_wdata,
    input  logic              wb_i_stall,
    input  logic              wb_i_flush,
    input  logic              rd0_en,
    input  logic [AW-1:0]     rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              rd1_en,
    input  logic [AW-1:0]     rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              wb_o_wreg,
    output logic [AW-1:0]     wb_o_waddr,
    output logic [DATA_W-1:0] wb_o_wdata
);

    import wb_regfile_pkg::*;

    localparam logic [AW-1:0] R0 = '0;

    // MEM/WB latch
    always_ff @(posedge clk) begin
        if (!rst_ || wb_i_flush) begin
            wb_o_wreg  <= WRITE_DISABLE;
            wb_o_waddr <= R0;
            wb_o_wdata <= '0;
        end else if (!wb_i_stall) begin
            wb_o_wreg  <= wb_i_wreg;
            wb_o_waddr <= wb_i_waddr;
            wb_o_wdata <= wb_i_wdata;
        end
    end

    // r0 writes never reach the array; a held latch during stall simply
    // rewrites the same value every cycle.
    logic commit;
    assign commit = (wb_o_wreg == WRITE_ENABLE) && (wb_o_waddr != R0);

    logic [RD_PORTS-1:0]             rd_en;
    logic [RD_PORTS-1:0][AW-1:0]     rd_addr;
    logic [RD_PORTS-1:0][DATA_W-1:0] ram_data;
    logic [RD_PORTS-1:0][DATA_W-1:0] rd_data;

    assign rd_en    = {rd1_en, rd0_en};
    assign rd_addr  = {rd1_addr, rd0_addr};
    assign rd0_data = rd_data[0];
    assign rd1_data = rd_data[1];

    regfile_ram #(
        .REG_NUM (REG_NUM),
        .DATA_W  (DATA_W),
        .NRD     (RD_PORTS)
    ) u_ram (
        .clk   (clk),
        .rst_  (rst_),
        .we    (commit),
        .waddr (wb_o_waddr),
        .wdata (wb_o_wdata),
        .raddr (rd_addr),
        .rdata (ram_data)
    );

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        always_comb begin
            rd_data[p] = '0;
            // r0 check comes before the bypass so a pending r0 write can
            // never leak through the forward path.
            if (rst_ && rd_en[p] && rd_addr[p] != R0) begin
`ifdef REGFILE_BYPASS_EN
                if (wb_o_wreg == WRITE_ENABLE && wb_o_waddr == rd_addr[p])
                    rd_data[p] = wb_o_wdata;
                else
                    rd_data[p] = ram_data[p];
`else
                rd_data[p] = ram_data[p];
`endif
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_;
    logic        wb_i_wreg;
    logic [4:0]  wb_i_waddr;
    logic [31:0] wb_i_wdata;
    logic        wb_i_stall, wb_i_flush;
    logic        rd0_en, rd1_en;
    logic [4:0]  rd0_addr, rd1_addr;
    logic [31:0] rd0_data, rd1_data;
    logic        wb_o_wreg;
    logic [4:0]  wb_o_waddr;
    logic [31:0] wb_o_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .rst_       (rst_),
        .wb_i_wreg  (wb_i_wreg),
        .wb_i_waddr (wb_i_waddr),
        .wb_i_wdata (wb_i_wdata),
        .wb_i_stall (wb_i_stall),
        .wb_i_flush (wb_i_flush),
        .rd0_en     (rd0_en),
        .rd0_addr   (rd0_addr),
        .rd0_data   (rd0_data),
        .rd1_en     (rd1_en),
        .rd1_addr   (rd1_addr),
        .rd1_data   (rd1_data),
        .wb_o_wreg  (wb_o_wreg),
        .wb_o_waddr (wb_o_waddr),
        .wb_o_wdata (wb_o_wdata)
    );

    // One row = inputs held across one rising edge; expectations are the
    // outputs observed just after that edge with the same inputs applied.
    typedef struct {
        logic        rst_;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        stall, flush;
        logic        e0;
        logic [4:0]  a0;
        logic        e1;
        logic [4:0]  a1;
        logic        xwreg;
        logic [4:0]  xwaddr;
        logic [31:0] xwdata;
        logic [31:0] xr0, xr1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
        input logic st, input logic fl,
        input logic e0, input logic [4:0] a0, input logic e1, input logic [4:0] a1,
        input logic xw, input logic [4:0] xa, input logic [31:0] xd,
        input logic [31:0] x0, input logic [31:0] x1);
        vec_t v;
        v.rst_ = r; v.wreg = w; v.waddr = wa; v.wdata = wd;
        v.stall = st; v.flush = fl;
        v.e0 = e0; v.a0 = a0; v.e1 = e1; v.a1 = a1;
        v.xwreg = xw; v.xwaddr = xa; v.xwdata = xd; v.xr0 = x0; v.xr1 = x1;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic st, input logic fl,
                         input logic e0, input logic [4:0] a0,
                         input logic e1, input logic [4:0] a1);
        @(negedge clk);
        rst_ = r; wb_i_wreg = w; wb_i_waddr = wa; wb_i_wdata = wd;
        wb_i_stall = st; wb_i_flush = fl;
        rd0_en = e0; rd0_addr = a0; rd1_en = e1; rd1_addr = a1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ = 1'b0; wb_i_wreg = 0; wb_i_waddr = 0; wb_i_wdata = 0;
        wb_i_stall = 0; wb_i_flush = 0;
        rd0_en = 0; rd0_addr = 0; rd1_en = 0; rd1_addr = 0;

        //                r  w  wa     wd            st fl e0 a0     e1 a1      xw xa     xd            xr0                         xr1
        // reset, read r5/r31
        vecs.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 1, 5'd5,  1, 5'd31,  0, 5'd0,  32'h0,        32'h0,                      32'h0));
        vecs.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 1, 5'd5,  1, 5'd31,  0, 5'd0,  32'h0,        32'h0,                      32'h0));
        // basic write r3 <= DEADBEEF: N+1 via bypass only, N+2 always
        vecs.push_back(mk(1, 1, 5'd3,  32'hDEADBEEF, 0, 0, 1, 5'd3,  1, 5'd3,   1, 5'd3,  32'hDEADBEEF, BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,        0, 0, 1, 5'd3,  1, 5'd3,   0, 5'd0,  32'h0,        32'hDEADBEEF,               32'hDEADBEEF));
        // r0 write is latched but never visible
        vecs.push_back(mk(1, 1, 5'd0,  32'hFFFFFFFF, 0, 0, 1, 5'd0,  1, 5'd0,   1, 5'd0,  32'hFFFFFFFF, 32'h0,                      32'h0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,        0, 0, 1, 5'd0,  1, 5'd0,   0, 5'd0,  32'h0,        32'h0,                      32'h0));
        // r7 <= 77, then stall with a new r7 <= 1 presented
        vecs.push_back(mk(1, 1, 5'd7,  32'h77,       0, 0, 1, 5'd7,  1, 5'd3,   1, 5'd7,  32'h77,       BYP ? 32'h77 : 32'h0,       32'hDEADBEEF));
        vecs.push_back(mk(1, 1, 5'd7,  32'h1,        1, 0, 1, 5'd7,  1, 5'd3,   1, 5'd7,  32'h77,       32'h77,                     32'hDEADBEEF));
        vecs.push_back(mk(1, 1, 5'd7,  32'h1,        1, 0, 1, 5'd7,  1, 5'd3,   1, 5'd7,  32'h77,       32'h77,                     32'hDEADBEEF));
        // flush + stall: latch cleared, r7 never takes 1
        vecs.push_back(mk(1, 1, 5'd7,  32'h1,        1, 1, 1, 5'd7,  1, 5'd3,   0, 5'd0,  32'h0,        32'h77,                     32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,        0, 0, 1, 5'd7,  1, 5'd7,   0, 5'd0,  32'h0,        32'h77,                     32'h77));
        // reset mid-operation drops pending r9 write and clears the array
        vecs.push_back(mk(1, 1, 5'd9,  32'hA5A5A5A5, 0, 0, 1, 5'd9,  1, 5'd7,   1, 5'd9,  32'hA5A5A5A5, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h77));
        vecs.push_back(mk(0, 0, 5'd0,  32'h0,        0, 0, 1, 5'd9,  1, 5'd7,   0, 5'd0,  32'h0,        32'h0,                      32'h0));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,        0, 0, 1, 5'd9,  1, 5'd7,   0, 5'd0,  32'h0,        32'h0,                      32'h0));
        // dual read of r12 while it is rewritten
        vecs.push_back(mk(1, 1, 5'd12, 32'h12345678, 0, 0, 1, 5'd12, 1, 5'd12,  1, 5'd12, 32'h12345678, BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0));
        vecs.push_back(mk(1, 1, 5'd12, 32'h0BADF00D, 0, 0, 1, 5'd12, 1, 5'd12,  1, 5'd12, 32'h0BADF00D, BYP ? 32'h0BADF00D : 32'h12345678, BYP ? 32'h0BADF00D : 32'h12345678));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,        0, 0, 1, 5'd12, 1, 5'd12,  0, 5'd0,  32'h0,        32'h0BADF00D,               32'h0BADF00D));
        // disabled port returns 0
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,        0, 0, 0, 5'd12, 1, 5'd12,  0, 5'd0,  32'h0,        32'h0,                      32'h0BADF00D));
        // flush alone drops the presented write
        vecs.push_back(mk(1, 1, 5'd5,  32'h55,       0, 1, 1, 5'd5,  1, 5'd12,  0, 5'd0,  32'h0,        32'h0,                      32'h0BADF00D));
        vecs.push_back(mk(1, 0, 5'd0,  32'h0,        0, 0, 1, 5'd5,  0, 5'd12,  0, 5'd0,  32'h0,        32'h0,                      32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_, vecs[i].wreg, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].stall, vecs[i].flush,
                  vecs[i].e0, vecs[i].a0, vecs[i].e1, vecs[i].a1);
            chk("wb_o_wreg",  i, {31'h0, wb_o_wreg},  {31'h0, vecs[i].xwreg});
            chk("wb_o_waddr", i, {27'h0, wb_o_waddr}, {27'h0, vecs[i].xwaddr});
            chk("wb_o_wdata", i, wb_o_wdata, vecs[i].xwdata);
            chk("rd0_data",   i, rd0_data, vecs[i].xr0);
            chk("rd1_data",   i, rd1_data, vecs[i].xr1);
        end

        // Back-to-back writes to different registers: each port tracks its
        // own register while the other is committing.
        drive(1, 1, 5'd20, 32'h20, 0, 0, 1, 5'd20, 1, 5'd21);
        chk("b2b rd0 a", 100, rd0_data, BYP ? 32'h20 : 32'h0);
        chk("b2b rd1 a", 100, rd1_data, 32'h0);
        drive(1, 1, 5'd21, 32'h21, 0, 0, 1, 5'd20, 1, 5'd21);
        chk("b2b rd0 b", 101, rd0_data, 32'h20);
        chk("b2b rd1 b", 101, rd1_data, BYP ? 32'h21 : 32'h0);
        drive(1, 0, 5'd0, 32'h0, 0, 0, 1, 5'd20, 1, 5'd21);
        chk("b2b rd0 c", 102, rd0_data, 32'h20);
        chk("b2b rd1 c", 102, rd1_data, 32'h21);

        // Async read path: change address mid-cycle without a clock edge.
        @(negedge clk);
        rd0_addr = 5'd3;
        #1;
        chk("async rd0 r3", 103, rd0_data, 32'h0);
        rd0_addr = 5'd21;
        #1;
        chk("async rd0 r21", 104, rd0_data, 32'h21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
